sel5_dispatch_ctrl: RTL and testbench

SEL5_DISPATCH_CTRL -- requirements
Module: sel5_dispatch_ctrl

---
 rtl/sel5_pkg.sv | 34 +++
 rtl/sel5_dispatch_ctrl_free_sync_edge.sv | 33 +++
 rtl/sel5_dispatch_ctrl.sv | 145 ++++++++++++++
 tb/tb_sel5_dispatch_ctrl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/sel5_pkg.sv
// Shared types for the 5-way selector dispatch controller.
// Holds the FSM state encoding, response error codes, the response payload
// and the branch count, along with a one-hot helper for branch selects.
package sel5_pkg;

    localparam int unsigned NUM_BRANCH = 5;
    localparam int unsigned DEST_W     = 3;
    localparam int unsigned CNT_W      = 16;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        DRIVE,
        WAIT_FREE,
        RESP
    } state_t;

    typedef enum logic [1:0] {
        ERR_OK       = 2'b00,
        ERR_BAD_DEST = 2'b01,
        ERR_TIMEOUT  = 2'b10
    } rsp_err_t;

    typedef struct packed {
        logic [DEST_W-1:0] dest;
        rsp_err_t          err;
    } rsp_t;

    // One-hot branch select for a destination index already known to be in range.
    function automatic logic [NUM_BRANCH-1:0] dest_onehot(input logic [DEST_W-1:0] dest);
        return NUM_BRANCH'(1) << dest;
    endfunction

endpackage

// File: rtl/sel5_dispatch_ctrl_free_sync_edge.sv
// Brings the selector's asynchronous free indication into the clk domain
// and turns its rising edge into a one-cycle pulse.
//   clk, rst     : clock and synchronous active-high reset
//   free_in      : raw free level from the selector (asynchronous)
//   free_pulse_c : one-cycle pulse on a synchronized rising edge; decoded
//                  from flops only, so there is no path from free_in
module free_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic free_in,
    output logic free_pulse_c
);

    logic sync_meta;
    logic sync_q;
    logic edge_q;

    // Two synchronizer stages followed by the edge-history flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_meta <= 1'b0;
            sync_q    <= 1'b0;
            edge_q    <= 1'b0;
        end else begin
            sync_meta <= free_in;
            sync_q    <= sync_meta;
            edge_q    <= sync_q;
        end
    end

    assign free_pulse_c = sync_q & ~edge_q;

endmodule

// File: rtl/sel5_dispatch_ctrl.sv
// Dispatch controller for a 5-way selector: accepts one request at a time,
// presents a one-hot branch select, pulses the selector's drive input, waits
// for the selector to report free (or times out) and returns a response.
//   clk, rst             : clock and synchronous active-high reset
//   req_valid/req_ready  : request handshake, req_dest = branch index 0..4
//   o_valid, o_drive     : one-hot branch select and drive pulse to selector
//   i_free               : selector free level (asynchronous to clk)
//   rsp_valid/rsp_ready  : response handshake with rsp_dest and rsp_err
//   busy                 : controller is handling a request
module sel5_dispatch_ctrl
    import sel5_pkg::*;
#(
    parameter int unsigned DRIVE_W = 2,
    parameter int unsigned SETUP_W = 1,
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [DEST_W-1:0]     req_dest,
    output logic [NUM_BRANCH-1:0] o_valid,
    output logic                  o_drive,
    input  logic                  i_free,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DEST_W-1:0]     rsp_dest,
    output logic [1:0]            rsp_err,
    output logic                  busy
);

    localparam logic [CNT_W-1:0] SETUP_LAST   = CNT_W'(SETUP_W - 1);
    localparam logic [CNT_W-1:0] DRIVE_LAST   = CNT_W'(DRIVE_W - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DEST_W-1:0]     dest_q, dest_d;
    rsp_t                  rsp_q, rsp_d;
    logic [NUM_BRANCH-1:0] o_valid_d;
    logic                  free_pulse_c;
    logic                  spurious_free;

    free_sync_edge u_free_sync_edge (
        .clk          (clk),
        .rst          (rst),
        .free_in      (i_free),
        .free_pulse_c (free_pulse_c)
    );

    // Next-state, counter and response payload.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dest_d    = dest_q;
        rsp_d     = rsp_q;
        o_valid_d = o_valid;

        case (state_q)
            IDLE: begin
                if (req_valid && req_ready) begin
                    dest_d = req_dest;
                    cnt_d  = '0;
                    if (req_dest >= DEST_W'(NUM_BRANCH)) begin
                        state_d = RESP;
                        rsp_d   = '{dest: req_dest, err: ERR_BAD_DEST};
                    end else begin
                        state_d   = SETUP;
                        o_valid_d = dest_onehot(req_dest);
                    end
                end
            end
            SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    state_d = DRIVE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DRIVE: begin
                if (cnt_q == DRIVE_LAST) begin
                    state_d = WAIT_FREE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WAIT_FREE: begin
                // A free edge takes priority over a timeout landing in the same cycle.
                if (free_pulse_c) begin
                    state_d = RESP;
                    rsp_d   = '{dest: dest_q, err: ERR_OK};
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d = RESP;
                    rsp_d   = '{dest: dest_q, err: ERR_TIMEOUT};
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d   = IDLE;
                    o_valid_d = '0;
                end
            end
            default: begin
                state_d   = IDLE;
                o_valid_d = '0;
            end
        endcase
    end

    // State register and registered outputs derived from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            dest_q        <= '0;
            rsp_q         <= '0;
            o_valid       <= '0;
            o_drive       <= 1'b0;
            rsp_valid     <= 1'b0;
            req_ready     <= 1'b0;
            busy          <= 1'b0;
            spurious_free <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            dest_q        <= dest_d;
            rsp_q         <= rsp_d;
            o_valid       <= o_valid_d;
            o_drive       <= (state_d == DRIVE);
            rsp_valid     <= (state_d == RESP);
            req_ready     <= (state_d == IDLE);
            busy          <= (state_d != IDLE);
            // Sticky record of free edges arriving outside WAIT_FREE.
            spurious_free <= spurious_free | (free_pulse_c && (state_q != WAIT_FREE));
        end
    end

    assign rsp_dest = rsp_q.dest;
    assign rsp_err  = rsp_q.err;

endmodule

// File: tb/tb_sel5_dispatch_ctrl.sv
module tb_sel5_dispatch_ctrl;

    localparam int S = 1;
    localparam int D = 2;
    localparam int T = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic [2:0] req_dest;
    logic [4:0] o_valid;
    logic       o_drive;
    logic       i_free;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [2:0] rsp_dest;
    logic [1:0] rsp_err;
    logic       busy;

    int n_pass  = 0;
    int n_total = 0;
    bit spur_model = 1'b0;

    always #5 clk = ~clk;

    sel5_dispatch_ctrl #(
        .DRIVE_W (D),
        .SETUP_W (S),
        .TIMEOUT (T)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_dest  (req_dest),
        .o_valid   (o_valid),
        .o_drive   (o_drive),
        .i_free    (i_free),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_dest  (rsp_dest),
        .rsp_err   (rsp_err),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_total++;
        assert (obs === exp_v) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    // One request end to end. Cycle 0 presents the request; p is the cycle in
    // which a one-cycle i_free pulse is driven (-1 = none); bp is the number of
    // RESP cycles with rsp_ready held low before the handshake.
    task automatic run_txn(input int dest, input int p, input int bp);
        bit         good;
        bit         edge_in_window;
        int         e;
        int         r;
        int         err_exp;
        logic [4:0] oh;
        good = (dest < 5);
        e    = 1 + S + D;                    // first WAIT_FREE cycle
        // Synchronizer + edge flop: a pulse in cycle p is acted on in cycle p+2.
        edge_in_window = good && (p >= 0) && (p + 2 >= e) && (p + 2 <= e + T - 1);
        if (!good) begin
            r       = 1;
            err_exp = 1;
        end else if (edge_in_window) begin
            r       = p + 3;
            err_exp = 0;
        end else begin
            r       = e + T;
            err_exp = 2;
        end
        oh = 5'd0;
        if (good) oh = 5'(1 << dest);
        if (good && p >= 0 && p + 2 < e) spur_model = 1'b1;

        next_cycle();
        req_valid = 1'b1;
        req_dest  = 3'(dest);
        i_free    = 1'b0;
        rsp_ready = 1'($urandom_range(0, 1));
        sample();
        chk("req_ready_idle", 32'(req_ready), 32'd1);
        chk("busy_idle", 32'(busy), 32'd0);
        chk("o_valid_idle", 32'(o_valid), 32'd0);

        for (int k = 1; k <= r + bp + 1; k++) begin
            next_cycle();
            // Requests presented while busy must never be taken.
            req_valid = (k <= r + bp) ? 1'($urandom_range(0, 1)) : 1'b0;
            req_dest  = 3'($urandom_range(0, 7));
            i_free    = (k == p);
            rsp_ready = (k < r) ? 1'($urandom_range(0, 1)) : (k == r + bp);
            sample();
            if (k <= r + bp) begin
                chk("o_valid", 32'(o_valid), 32'(oh));
                chk("o_drive", 32'(o_drive), 32'(good && k >= 1 + S && k <= S + D));
                chk("rsp_valid", 32'(rsp_valid), 32'(k >= r));
                chk("req_ready_busy", 32'(req_ready), 32'd0);
                chk("busy", 32'(busy), 32'd1);
                if (k >= r) begin
                    chk("rsp_dest", 32'(rsp_dest), 32'(dest));
                    chk("rsp_err", 32'(rsp_err), 32'(err_exp));
                end
            end else begin
                chk("o_valid_after", 32'(o_valid), 32'd0);
                chk("o_drive_after", 32'(o_drive), 32'd0);
                chk("rsp_valid_after", 32'(rsp_valid), 32'd0);
                chk("busy_after", 32'(busy), 32'd0);
                chk("req_ready_after", 32'(req_ready), 32'd1);
            end
        end
        chk("spurious_free", 32'(dut.spurious_free), 32'(spur_model));
    endtask

    initial begin
        int dest;
        int mode;
        int p;
        int bp;

        rst       = 1'b1;
        req_valid = 1'b0;
        req_dest  = 3'd0;
        i_free    = 1'b0;
        rsp_ready = 1'b0;
        repeat (3) next_cycle();
        sample();
        chk("rst_o_valid", 32'(o_valid), 32'd0);
        chk("rst_o_drive", 32'(o_drive), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_dest", 32'(rsp_dest), 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_spurious", 32'(dut.spurious_free), 32'd0);
        next_cycle();
        rst = 1'b0;
        sample();

        // Basic: dest 2, free pulse at cycle 10, response in cycle 13.
        run_txn(2, 10, 0);
        // Bad destination.
        run_txn(6, -1, 0);
        run_txn(5, -1, 2);
        // Timeout with i_free held low.
        run_txn(4, -1, 1);
        // Free edge lands on the final timeout cycle.
        run_txn(0, 1 + S + D + T - 3, 0);
        // Backpressure with a free pulse during DRIVE.
        run_txn(3, 1, 5);

        // Reset asserted during DRIVE.
        next_cycle();
        req_valid = 1'b1;
        req_dest  = 3'd1;
        next_cycle();
        req_valid = 1'b0;
        next_cycle();
        sample();
        chk("mid_drive_o_drive", 32'(o_drive), 32'd1);
        rst = 1'b1;
        next_cycle();
        sample();
        spur_model = 1'b0;
        chk("mid_rst_o_drive", 32'(o_drive), 32'd0);
        chk("mid_rst_o_valid", 32'(o_valid), 32'd0);
        chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_req_ready", 32'(req_ready), 32'd0);
        chk("mid_rst_spurious", 32'(dut.spurious_free), 32'd0);
        rst = 1'b0;
        next_cycle();
        sample();
        chk("post_rst_o_drive", 32'(o_drive), 32'd0);
        chk("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        run_txn(1, 8, 0);

        // Randomized requests.
        for (int n = 0; n < 40; n++) begin
            dest = $urandom_range(0, 7);
            mode = $urandom_range(0, 2);
            bp   = $urandom_range(0, 4);
            if (dest > 4 || mode == 0) p = -1;
            else if (mode == 1) p = (1 + S + D - 2) + $urandom_range(0, T - 1);
            else p = $urandom_range(1, 1 + S + D - 3);
            run_txn(dest, p, bp);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
